// File: rtl/mips_pkg.sv
// Shared MIPS constants and the write-back queue entry type.
// wb_entry_t fixes the data field at WB_DATA_W, so queue instances keep DATA_W == WB_DATA_W.
package mips_pkg;
    localparam int REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
    localparam int WB_DATA_W = 32;
    localparam int WB_DEPTH = 4;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [WB_DATA_W-1:0]  data;
    } wb_entry_t;
endpackage

// File: rtl/regfile_wb_queue_if.sv
// Bundle of the write-back queue's upstream, register-file and decode-lookup signals.
interface regfile_wb_queue_if
    import mips_pkg::*;
#(
    parameter int DEPTH  = WB_DEPTH,
    parameter int DATA_W = WB_DATA_W
);
    logic                     in_valid;
    logic                     in_ready;
    logic [REG_ADDR_W-1:0]    in_rd;
    logic [DATA_W-1:0]        in_data;
    logic                     wr_en;
    logic                     wr_ready;
    logic [REG_ADDR_W-1:0]    wr_addr;
    logic [DATA_W-1:0]        wr_data;
    logic [REG_ADDR_W-1:0]    q_addr1, q_addr2;
    logic                     q_pend1, q_pend2;
    logic [DATA_W-1:0]        q_data1, q_data2;
    logic [$clog2(DEPTH):0]   count;

    modport master (
        output in_valid, in_rd, in_data, wr_ready, q_addr1, q_addr2,
        input  in_ready, wr_en, wr_addr, wr_data, q_pend1, q_pend2, q_data1, q_data2, count
    );
    modport slave (
        input  in_valid, in_rd, in_data, wr_ready, q_addr1, q_addr2,
        output in_ready, wr_en, wr_addr, wr_data, q_pend1, q_pend2, q_data1, q_data2, count
    );
endinterface

// File: rtl/wb_lookup.sv
// One decode read-port lookup: pending-write hit and, with WB_BYPASS_EN, youngest-match data.
// Without WB_BYPASS_EN the data output is tied to zero.
module wb_lookup
    import mips_pkg::*;
#(
    parameter int DEPTH  = WB_DEPTH,
    parameter int DATA_W = WB_DATA_W,
    localparam int PW    = $clog2(DEPTH)
) (
    input  wb_entry_t [DEPTH-1:0] entries,
    input  logic [DEPTH-1:0]      valid,
    input  logic [PW-1:0]         head,
    input  logic [REG_ADDR_W-1:0] addr,
    output logic                  pend,
    output logic [DATA_W-1:0]     data
);
    logic [DEPTH-1:0] hit;

    // r0 can never be pending, so a zero address masks every hit.
    always_comb begin
        hit = '0;
        for (int i = 0; i < DEPTH; i++)
            hit[i] = valid[i] && (entries[i].rd == addr) && (addr != REG_ZERO);
    end

    assign pend = |hit;

`ifdef WB_BYPASS_EN
    // Walk oldest to youngest so the last hit seen is the youngest.
    always_comb begin : youngest
        logic [PW-1:0] idx;
        idx  = '0;
        data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head + PW'(k);
            if (hit[idx]) data = entries[idx].data;
        end
    end
`else
    logic unusedOk;
    assign unusedOk = ^{head, entries};
    assign data = '0;
`endif
endmodule

// File: rtl/regfile_wb_queue.sv
// In-order write-back FIFO feeding the register file write port, with two decode lookups.
// Optional WB_BYPASS_EN enables youngest-match data forwarding on the lookup ports.
module regfile_wb_queue
    import mips_pkg::*;
#(
    parameter int DEPTH  = WB_DEPTH,
    parameter int DATA_W = WB_DATA_W
) (
    input logic clk,
    input logic rst,
    regfile_wb_queue_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    wb_entry_t [DEPTH-1:0] mem;
    logic [PW-1:0]         head, tail;
    logic [CW-1:0]         cnt;
    logic [DEPTH-1:0]      vld;
    logic                  inReady, wrEn, push, pushQ, pop;

    assign inReady = cnt < CW'(DEPTH);
    assign wrEn    = cnt != '0;
    assign push    = bus.in_valid && inReady;
    assign pushQ   = push && (bus.in_rd != REG_ZERO);
    assign pop     = wrEn && bus.wr_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else begin
            if (pushQ) tail <= tail + 1'b1;
            if (pop)   head <= head + 1'b1;
            case ({pushQ, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Payload storage needs no reset: occupancy alone decides what is live.
    always_ff @(posedge clk) begin
        if (pushQ) mem[tail] <= '{rd: bus.in_rd, data: bus.in_data};
    end

    always_comb begin : vldGen
        logic [PW-1:0] off;
        off = '0;
        vld = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off    = PW'(i) - head;
            vld[i] = {1'b0, off} < cnt;
        end
    end

    assign bus.in_ready = inReady;
    assign bus.wr_en    = wrEn;
    assign bus.wr_addr  = wrEn ? mem[head].rd : '0;
    assign bus.wr_data  = wrEn ? mem[head].data : '0;
    assign bus.count    = cnt;

    logic [1:0][REG_ADDR_W-1:0] qAddr;
    logic [1:0]                 qPend;
    logic [1:0][DATA_W-1:0]     qData;

    assign qAddr = {bus.q_addr2, bus.q_addr1};

    for (genvar p = 0; p < 2; p++) begin : g_lk
        wb_lookup #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_lk (
            .entries (mem),
            .valid   (vld),
            .head    (head),
            .addr    (qAddr[p]),
            .pend    (qPend[p]),
            .data    (qData[p])
        );
    end

    assign bus.q_pend1 = qPend[0];
    assign bus.q_pend2 = qPend[1];
    assign bus.q_data1 = qData[0];
    assign bus.q_data2 = qData[1];
endmodule

// File: tb/tb_regfile_wb_queue.sv
// Randomized + directed bench for regfile_wb_queue against a queue-based reference model.
// Follows WB_BYPASS_EN the same way the design does for q_data expectations.
module tb_regfile_wb_queue;
    localparam int DEPTH = 4;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   nChk = 0;
    int   nErr = 0;
    ent_t mq[$];

    regfile_wb_queue_if #(.DEPTH(DEPTH), .DATA_W(32)) bus ();

    regfile_wb_queue #(.DEPTH(DEPTH), .DATA_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChk++;
        if (got !== exp) begin
            nErr++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference lookup: pending if any queued write targets addr; data is the youngest match.
    task automatic look(input logic [4:0] a, output logic pend, output logic [31:0] d);
        pend = 1'b0;
        d    = '0;
        if (a != 0)
            foreach (mq[i])
                if (mq[i].rd == a) begin
                    pend = 1'b1;
                    d    = mq[i].data;
                end
`ifndef WB_BYPASS_EN
        d = '0;
`endif
    endtask

    // Called at a negedge: drive, check settled outputs, then advance the model across the edge.
    task automatic cycle(input bit iv, input logic [4:0] rd, input logic [31:0] d,
                         input bit wrr, input logic [4:0] a1, input logic [4:0] a2);
        logic        pnd;
        logic [31:0] qd;
        bit          push, pop;
        bus.in_valid = iv;
        bus.in_rd    = rd;
        bus.in_data  = d;
        bus.wr_ready = wrr;
        bus.q_addr1  = a1;
        bus.q_addr2  = a2;
        #1;
        chk("count",    32'(bus.count),    32'(mq.size()));
        chk("in_ready", 32'(bus.in_ready), 32'(mq.size() < DEPTH));
        chk("wr_en",    32'(bus.wr_en),    32'(mq.size() != 0));
        chk("wr_addr",  32'(bus.wr_addr),  mq.size() != 0 ? 32'(mq[0].rd) : 32'd0);
        chk("wr_data",  bus.wr_data,       mq.size() != 0 ? mq[0].data : 32'd0);
        look(a1, pnd, qd);
        chk("q_pend1", 32'(bus.q_pend1), 32'(pnd));
        chk("q_data1", bus.q_data1, qd);
        look(a2, pnd, qd);
        chk("q_pend2", 32'(bus.q_pend2), 32'(pnd));
        chk("q_data2", bus.q_data2, qd);
        push = iv && (mq.size() < DEPTH);
        pop  = (mq.size() != 0) && wrr;
        @(posedge clk);
        if (pop) void'(mq.pop_front());
        if (push && rd != 0) mq.push_back('{rd: rd, data: d});
        @(negedge clk);
    endtask

    task automatic doReset();
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.wr_ready = 1'b0;
        @(posedge clk);
        mq.delete();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_rd    = '0;
        bus.in_data  = '0;
        bus.wr_ready = 1'b0;
        bus.q_addr1  = '0;
        bus.q_addr2  = '0;
        @(negedge clk);
        doReset();

        // Single push with file ready: one-cycle latency, then empty.
        cycle(1, 5, 32'hDEADBEEF, 1, 5, 0);
        cycle(0, 0, 0, 1, 5, 3);
        cycle(0, 0, 0, 1, 5, 0);

        // Fill while the file stalls, reject a 5th, then drain in order.
        for (int i = 1; i <= 4; i++) cycle(1, 5'(i), 32'h100 + 32'(i), 0, 5'(i), 2);
        cycle(1, 9, 32'h999, 0, 9, 4);
        for (int i = 0; i < 5; i++) cycle(0, 0, 0, 1, 3, 4);

        // r0 writes are handshaken and dropped.
        cycle(1, 0, 32'h1234, 1, 0, 0);
        cycle(0, 0, 0, 1, 0, 0);

        // Two writes to r7 in flight: youngest forwarded, both retire oldest first.
        cycle(1, 7, 32'h11, 0, 7, 0);
        cycle(1, 7, 32'h22, 0, 7, 7);
        cycle(0, 0, 0, 0, 7, 1);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1, 7, 0);

        // Steady state at occupancy 2 with simultaneous push and pop.
        cycle(1, 3, 32'hA0, 0, 3, 0);
        cycle(1, 4, 32'hA1, 0, 4, 0);
        for (int i = 0; i < 10; i++) cycle(1, 5'(10 + i), 32'hB0 + 32'(i), 1, 5'(10 + i), 5'(8 + i));
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1, 18, 19);

        // Reset mid-operation drops queued writes.
        for (int i = 0; i < 3; i++) cycle(1, 5'(20 + i), 32'hC0 + 32'(i), 0, 21, 22);
        doReset();
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1, 20, 22);

        // Random traffic over a small register range to provoke hits and wraps.
        for (int i = 0; i < 400; i++)
            cycle($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), $urandom,
                  $urandom_range(0, 2) != 0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        for (int i = 0; i < 6; i++) cycle(0, 0, 0, 1, 1, 2);

        $display("Result: errors=%0d of %0d checks", nErr, nChk);
        $finish;
    end
endmodule
